// File: rtl/sub_12_bit_serial.sv
// Bit-serial unsigned subtractor: one full-subtractor cell with a registered borrow
// produces one difference bit per clock, LSB first, and holds the result until the next job completes.
module sub_12_bit_serial #(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             b
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_r;
   logic             r_borrow;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_d;
   logic             r_bout;

   logic             w_diff;
   logic             w_borrow_next;
   logic             w_last;

   // Full-subtractor cell on the operand LSBs.
   assign w_diff        = r_a[0] ^ r_b[0] ^ r_borrow;
   assign w_borrow_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_borrow);
   assign w_last        = (r_cnt == CW'(WIDTH - 1));

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // busy/done are registered from the next state, so they never decode combinationally off inputs.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next == S_RUN);
         r_done  <= (w_next == S_DONE);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_r      <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
         r_d      <= '0;
         r_bout   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a      <= in1;
                  r_b      <= in2;
                  r_borrow <= 1'b0;
                  r_cnt    <= '0;
               end
            end
            S_RUN: begin
               r_r      <= {w_diff, r_r[WIDTH-1:1]};
               r_a      <= {1'b0, r_a[WIDTH-1:1]};
               r_b      <= {1'b0, r_b[WIDTH-1:1]};
               r_borrow <= w_borrow_next;
               r_cnt    <= r_cnt + CW'(1);
               if (w_last) begin
                  r_d    <= {w_diff, r_r[WIDTH-1:1]};
                  r_bout <= w_borrow_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign d    = r_d;
   assign b    = r_bout;

endmodule

// File: tb/tb_sub_12_bit_serial.sv
// Scoreboard bench for sub_12_bit_serial: the driver queues expected results as it issues
// starts; a monitor pops and compares on every done pulse.
module tb_sub_12_bit_serial;

   localparam int WIDTH = 12;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] d;
   logic             b;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] s;
      logic [WIDTH-1:0] d;
      logic             b;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_issued = 0;
   int   n_done   = 0;

   sub_12_bit_serial #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .in1   (in1),
      .in2   (in2),
      .busy  (busy),
      .done  (done),
      .d     (d),
      .b     (b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
   endtask

   // Monitor: pops the scoreboard on done, checks busy length, and checks d/b stay put otherwise.
   initial begin : monitor
      int               busy_len;
      logic [WIDTH-1:0] prev_d;
      logic             prev_b;
      exp_t             e;
      busy_len = 0;
      prev_d   = '0;
      prev_b   = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy_len = 0;
         end else begin
            if (busy) busy_len++;
            if (done) begin
               n_done++;
               check("busy_and_done", {30'd0, busy, done}, 32'd1);
               check("busy_cycles", busy_len, WIDTH);
               busy_len = 0;
               if (exp_q.size() == 0) begin
                  check("unexpected_done", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("d", {20'd0, d}, {20'd0, e.d});
                  check("b", {31'd0, b}, {31'd0, e.b});
                  check("d_plus_in2", {20'd0, d + e.s}, {20'd0, e.a});
               end
            end else begin
               check("d_held", {19'd0, b, d}, {19'd0, prev_b, prev_d});
            end
         end
         prev_d = d;
         prev_b = b;
      end
   end

   // One job at maximum rate: start sampled at E0, returns in the DONE cycle so the next
   // call's start lands on E0+WIDTH+2.
   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] s,
                        input logic [WIDTH-1:0] ed, input logic eb, input bit push);
      exp_t e;
      @(negedge clk);
      in1   = a;
      in2   = s;
      start = 1'b1;
      if (push) begin
         e.a = a; e.s = s; e.d = ed; e.b = eb;
         exp_q.push_back(e);
         n_issued++;
      end
      @(negedge clk);
      start = 1'b0;
      repeat (WIDTH) @(negedge clk);
   endtask

   initial begin : driver
      exp_t             e;
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rs;
      int               wait_cycles;
      rst   = 1'b1;
      start = 1'b0;
      in1   = '0;
      in2   = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {18'd0, busy, done, d, b}, 32'd0);
      rst = 1'b0;

      // Directed vectors.
      issue(12'd100, 12'd37,  12'd63,    1'b0, 1'b1);
      issue(12'd37,  12'd100, 12'hFC1,   1'b1, 1'b1);
      issue(12'hFFF, 12'hFFF, 12'h000,   1'b0, 1'b1);
      issue(12'h000, 12'h001, 12'hFFF,   1'b1, 1'b1);
      issue(12'h800, 12'h7FF, 12'h001,   1'b0, 1'b1);
      issue(12'h5A5, 12'h0F0, 12'h4B5,   1'b0, 1'b1);

      // start held high with inputs wandering: only E0 and E0+14 may be accepted.
      @(negedge clk);
      in1 = 12'd1000; in2 = 12'd1;  start = 1'b1;
      e.a = 12'd1000; e.s = 12'd1; e.d = 12'd999; e.b = 1'b0;
      exp_q.push_back(e); n_issued++;
      for (int i = 0; i < WIDTH + 1; i++) begin
         @(negedge clk);
         in1 = 12'h123 + 12'(i);
         in2 = 12'hABC - 12'(i);
      end
      @(negedge clk);
      in1 = 12'd10; in2 = 12'd20;
      e.a = 12'd10; e.s = 12'd20; e.d = 12'hFF6; e.b = 1'b1;
      exp_q.push_back(e); n_issued++;
      @(negedge clk);
      start = 1'b0;
      check("restart_accepted", {31'd0, busy}, 32'd1);
      repeat (WIDTH) @(negedge clk);

      // Asynchronous reset after bit 5 of a job following a completed 100-37.
      issue(12'd100, 12'd37, 12'd63, 1'b0, 1'b1);
      @(negedge clk);
      in1 = 12'd200; in2 = 12'd50; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      #1 rst = 1'b1;
      #1 check("abort_outputs", {18'd0, busy, done, d, b}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      issue(12'd5, 12'd3, 12'd2, 1'b0, 1'b1);

      // Random pairs, back-to-back at maximum rate.
      for (int i = 0; i < 1000; i++) begin
         ra = 12'($urandom);
         rs = 12'($urandom);
         issue(ra, rs, ra - rs, (ra < rs), 1'b1);
      end

      wait_cycles = 0;
      while (exp_q.size() != 0 && wait_cycles < 100) begin
         @(negedge clk);
         wait_cycles++;
      end
      repeat (4) @(negedge clk);
      check("queue_drained", exp_q.size(), 32'd0);
      check("done_per_start", n_done, n_issued);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sub_12_bit_serial.md
# sub_12_bit_serial

Bit-serial 12-bit unsigned subtractor, the inverse-direction companion to the team's parallel 12-bit ripple adder. It accepts a minuend/subtrahend pair on a one-cycle start, computes one difference bit per clock through a single full-subtractor cell with a registered borrow, and reports a held difference plus borrow-out with a one-cycle done pulse. It serves datapaths where area matters more than latency. Its results must satisfy d + in2 ≡ in1 (mod 4096) against the parallel adder.

## Interface
Parameters:
- WIDTH, 12, operand/result width; counter sized ceil(log2(WIDTH)) bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  request; sampled only in IDLE.
- in1  input  WIDTH  minuend (unsigned); captured on accepted start.
- in2  input  WIDTH  subtrahend (unsigned); captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; d/b valid and new in that cycle.
- d  output  WIDTH  difference in1 − in2 mod 2^WIDTH; held until the next completion.
- b  output  1  borrow-out: 1 iff in1 < in2 (unsigned); held with d.

## Operation
- Reset (asserted at any time): state=IDLE, busy=0, done=0, d=0, b=0, internal shift registers/counter/borrow=0. Mid-operation reset aborts the job with no done.
- States: IDLE, RUN, DONE.
- IDLE: if start=1, load A<=in1, B<=in2, borrow<=0, cnt<=0, and go to RUN. Otherwise stay.
- RUN, each cycle, on LSBs a=A[0], s=B[0], br=borrow:
  - diff = a ^ s ^ br
  - borrow_next = (~a & s) | (~(a ^ s) & br)
  - Shift diff into the MSB of the result shift register R; shift A and B right by one.
  - Increment cnt.
  - When cnt==WIDTH−1 (last bit), copy the final R into d and borrow_next into b, assert done, and go to DONE.
- DONE: one cycle; done=1, busy=0. Go to IDLE on the next edge.
- start is ignored in RUN and DONE (no queuing). in1/in2 changes after capture have no effect.
- d and b change only at completion. An aborted or ignored request leaves them unchanged.

## Timing
- Start accepted at edge E0. busy=1 from after E0 through the cycle ending at edge E0+WIDTH.
- Bit i is computed at edge E0+1+i (i=0..WIDTH−1).
- At edge E0+WIDTH: d/b update, done=1, busy=0 (DONE state).
- At edge E0+WIDTH+1: done=0, state IDLE.
- Earliest next accepted start is at edge E0+WIDTH+2. Throughput is one result per WIDTH+2 cycles.
- done and busy are never high in the same cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- in1=100, in2=37, start 1 cycle → exactly 12 cycles of busy, then done pulse with d=63, b=0.
- in1=37, in2=100 → d=4033 (0xFC1), b=1; check d+in2 mod 4096 = 37.
- Boundaries: 0xFFF−0xFFF → d=0, b=0; 0−1 → d=0xFFF, b=1; 0x800−0x7FF → d=1, b=0.
- start held high plus in1/in2 changed during RUN → exactly one done, with the result of the first captured pair. Next start accepted only at edge E0+14 with the new pair.
- rst asserted asynchronously after bit 5 of a job following a completed 100−37 → busy/done drop immediately, d=0, b=0, no done. A fresh 5−3 after release → d=2, b=0.
- Random 1000 pairs, back-to-back starts at maximum rate → every d equals (in1−in2) mod 4096, every b equals (in1<in2), one done per accepted start.
